// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises {rw, addr[6:0], wdata[7:0]} MSB first and captures the last 8 cipo bits.
// One frame in flight; request accepted only in IDLE, response is a single-cycle pulse at frame end.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] ph_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   tx_sr;
  logic [7:0]    rx_sr;
  logic          cipo_s1;
  logic          cipo_s2;
  logic          phase_done;

  assign phase_done = (ph_cnt == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ph_cnt    <= '0;
      bit_cnt   <= 4'd0;
      tx_sr     <= 16'h0000;
      rx_sr     <= 8'h00;
      cipo_s1   <= 1'b0;
      cipo_s2   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
    end else begin
      cipo_s1   <= cipo;
      cipo_s2   <= cipo_s1;
      rsp_valid <= 1'b0;
      // Every timed phase restarts its counter on entry and leaves on the CLK_DIV-th cycle.
      if (state != S_IDLE) begin
        ph_cnt <= phase_done ? '0 : ph_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= S_LEAD;
            tx_sr     <= {req_rw, req_addr, req_wdata};
            copi      <= req_rw;
            ncs       <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            ph_cnt    <= '0;
            bit_cnt   <= 4'd15;
          end
        end
        S_LEAD, S_LOW: begin
          if (phase_done) begin
            state <= S_HIGH;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], cipo_s2};
          end
        end
        S_HIGH: begin
          if (phase_done) begin
            sclk <= 1'b0;
            if (bit_cnt == 4'd0) begin
              state <= S_TRAIL;
            end else begin
              state   <= S_LOW;
              tx_sr   <= tx_sr << 1;
              copi    <= tx_sr[14];
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        S_TRAIL: begin
          if (phase_done) begin
            state     <= S_GAP;
            ncs       <= 1'b1;
            copi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_sr;
          end
        end
        S_GAP: begin
          if (phase_done) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
